// File: rtl/mole_round_ctrl.sv
// Whack-a-mole round controller.
// Raises one mole at a time at a pseudo-random hole and judges hits, wrong
// presses and timeouts. It keeps a saturating two-digit BCD score and a
// miss count, and enters OVER once the miss limit is reached.
module mole_round_ctrl #(
   parameter int          HOLES      = 4,
   parameter int          UP_TIME    = 50000000,
   parameter int          GAP_TIME   = 25000000,
   parameter int          MAX_MISSES = 5,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [HOLES-1:0] hit,
   output logic [HOLES-1:0] mole,
   output logic [7:0]       score_bcd,
   output logic [3:0]       misses,
   output logic             hit_flash,
   output logic             miss_flash,
   output logic             game_over
);

   localparam int HW   = $clog2(HOLES);
   localparam int TMAX = (UP_TIME > GAP_TIME) ? UP_TIME : GAP_TIME;
   localparam int TW   = $clog2(TMAX + 1);

   localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_TIME - 1);
   localparam logic [TW-1:0] UP_LAST   = TW'(UP_TIME - 1);
   localparam logic [3:0]    MISS_LIM  = 4'(MAX_MISSES);
   localparam logic [HOLES-1:0] ONE_HOT0 = {{(HOLES-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_IDLE,
      S_GAP,
      S_UP,
      S_OVER
   } state_t;

   state_t           r_state;
   logic [15:0]      r_lfsr;
   logic [TW-1:0]    r_timer;
   logic [HW-1:0]    r_hole;
   logic [HOLES-1:0] r_mole;
   logic [7:0]       r_score;
   logic [3:0]       r_misses;
   logic             r_hit_flash;
   logic             r_miss_flash;
   logic             r_game_over;

   logic             w_lfsr_fb;
   logic [HW-1:0]    w_cand;
   logic [HW-1:0]    w_pick;
   logic             w_hit_ok;
   logic             w_any_press;
   logic             w_up_done;
   logic [3:0]       w_miss_next;

   // Two-digit BCD increment that sticks at 99.
   function automatic logic [7:0] bcd_inc(input logic [7:0] v);
      logic [7:0] res;
      if (v == 8'h99)
         res = v;
      else if (v[3:0] == 4'd9)
         res = {v[7:4] + 4'd1, 4'd0};
      else
         res = {v[7:4], v[3:0] + 4'd1};
      return res;
   endfunction

   // Hole selection, hit judgement and the saturating miss count.
   always_comb begin
      w_lfsr_fb   = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
      w_cand      = r_lfsr[HW-1:0];
      // Bump past the previous hole so the same hole never repeats back to back.
      w_pick      = (w_cand == r_hole) ? w_cand + HW'(1) : w_cand;
      w_hit_ok    = hit[r_hole];
      w_any_press = |hit;
      w_up_done   = (r_timer == UP_LAST);
      w_miss_next = (r_misses == MISS_LIM) ? r_misses : r_misses + 4'd1;
   end

   // Round FSM: LFSR free-runs every cycle; all outputs are registered here.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_lfsr       <= LFSR_SEED;
         r_timer      <= '0;
         r_hole       <= '0;
         r_mole       <= '0;
         r_score      <= 8'h00;
         r_misses     <= 4'd0;
         r_hit_flash  <= 1'b0;
         r_miss_flash <= 1'b0;
         r_game_over  <= 1'b0;
      end else begin
         r_lfsr       <= {r_lfsr[14:0], w_lfsr_fb};
         r_hit_flash  <= 1'b0;
         r_miss_flash <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_score  <= 8'h00;
                  r_misses <= 4'd0;
                  r_timer  <= '0;
                  r_state  <= S_GAP;
               end
            end
            S_GAP: begin
               if (r_timer == GAP_LAST) begin
                  r_hole  <= w_pick;
                  r_mole  <= ONE_HOT0 << w_pick;
                  r_timer <= '0;
                  r_state <= S_UP;
               end else begin
                  r_timer <= r_timer + TW'(1);
               end
            end
            S_UP: begin
               // A correct press wins even if wrong bits or the timeout coincide.
               if (w_hit_ok) begin
                  r_score     <= bcd_inc(r_score);
                  r_hit_flash <= 1'b1;
                  r_mole      <= '0;
                  r_timer     <= '0;
                  r_state     <= S_GAP;
               end else if (w_any_press || w_up_done) begin
                  r_misses     <= w_miss_next;
                  r_miss_flash <= 1'b1;
                  r_mole       <= '0;
                  r_timer      <= '0;
                  if (w_miss_next == MISS_LIM) begin
                     r_game_over <= 1'b1;
                     r_state     <= S_OVER;
                  end else begin
                     r_state     <= S_GAP;
                  end
               end else begin
                  r_timer <= r_timer + TW'(1);
               end
            end
            S_OVER: begin
               if (start) begin
                  r_score     <= 8'h00;
                  r_misses    <= 4'd0;
                  r_timer     <= '0;
                  r_game_over <= 1'b0;
                  r_state     <= S_GAP;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign mole       = r_mole;
   assign score_bcd  = r_score;
   assign misses     = r_misses;
   assign hit_flash  = r_hit_flash;
   assign miss_flash = r_miss_flash;
   assign game_over  = r_game_over;

endmodule

// File: tb/tb_mole_round_ctrl.sv
// Bench for mole_round_ctrl: a table-driven full game (HOLES=4, UP_TIME=8,
// GAP_TIME=4, MAX_MISSES=3) followed by hand-written sequences for score
// saturation, restart from OVER and asynchronous reset mid-round.
module tb_mole_round_ctrl;

   localparam int          HOLES = 4;
   localparam logic [15:0] SEED  = 16'hACE1;

   logic             clock;
   logic             reset;
   logic             start;
   logic [HOLES-1:0] hit;
   logic [HOLES-1:0] mole;
   logic [7:0]       score_bcd;
   logic [3:0]       misses;
   logic             hit_flash;
   logic             miss_flash;
   logic             game_over;

   mole_round_ctrl #(
      .HOLES     (HOLES),
      .UP_TIME   (8),
      .GAP_TIME  (4),
      .MAX_MISSES(3),
      .LFSR_SEED (SEED)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .hit       (hit),
      .mole      (mole),
      .score_bcd (score_bcd),
      .misses    (misses),
      .hit_flash (hit_flash),
      .miss_flash(miss_flash),
      .game_over (game_over)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Reference LFSR: 16-bit Fibonacci, taps 16,14,13,11, shifting every cycle.
   logic [15:0] m_lfsr;
   logic [15:0] m_lfsr_prev;
   always @(posedge clock or posedge reset) begin
      if (reset) begin
         m_lfsr      <= SEED;
         m_lfsr_prev <= SEED;
      end else begin
         m_lfsr_prev <= m_lfsr;
         m_lfsr      <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
      end
   end

   int checks   = 0;
   int failures = 0;
   logic [1:0] exp_hole;
   logic [1:0] m_prev_hole;

   typedef struct {
      logic       st;
      logic [1:0] md;   // 0 none, 1 correct, 2 wrong, 3 correct+wrong
      logic       up;
      logic [7:0] sc;
      logic [3:0] mi;
      logic       hf;
      logic       mf;
      logic       go;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic add(input int n, input logic st, input logic [1:0] md, input logic up,
                      input logic [7:0] sc, input logic [3:0] mi,
                      input logic hf, input logic mf, input logic go);
      vec_t v;
      v.st = st; v.md = md; v.up = up; v.sc = sc; v.mi = mi;
      v.hf = hf; v.mf = mf; v.go = go;
      for (int k = 0; k < n; k++) vecs.push_back(v);
   endtask

   // Expected hole from the LFSR value present on the cycle the mole was raised.
   task automatic compute_hole();
      logic [1:0] cand;
      cand = m_lfsr_prev[1:0];
      if (cand == m_prev_hole) cand = cand + 2'd1;
      exp_hole    = cand;
      m_prev_hole = cand;
   endtask

   function automatic logic [3:0] hitvec(input logic [1:0] md);
      logic [3:0] ok, bad;
      ok  = 4'b0001 << exp_hole;
      bad = 4'b0001 << (exp_hole + 2'd1);
      case (md)
         2'd1:    return ok;
         2'd2:    return bad;
         2'd3:    return ok | bad;
         default: return 4'b0000;
      endcase
   endfunction

   function automatic logic [7:0] to_bcd(input int n);
      logic [3:0] t, u;
      t = 4'(n / 10);
      u = 4'(n % 10);
      return {t, u};
   endfunction

   // Waits up to 12 cycles for the mole; returns cycles waited.
   task automatic wait_mole(output int n);
      n = 0;
      while (mole == '0 && n < 12) begin
         tick();
         n++;
      end
      if (mole == '0) chk("mole_rise_timeout", 32'(mole), 32'hF);
      else begin
         compute_hole();
         chk("mole_onehot", 32'(mole), 32'(4'b0001 << exp_hole));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog_timeout actual=running expected=finished");
      $fatal(1);
   end

   initial begin
      int   n;
      logic prev_up;
      vec_t v;

      reset = 1'b0; start = 1'b0; hit = '0;
      m_prev_hole = 2'd0; exp_hole = 2'd0;
      #2 reset = 1'b1;
      tick(); tick();
      chk("rst_mole", 32'(mole), 0);
      chk("rst_score", 32'(score_bcd), 0);
      chk("rst_misses", 32'(misses), 0);
      chk("rst_flags", {29'd0, hit_flash, miss_flash, game_over}, 0);
      reset = 1'b0;

      // Idle: hit pulses must not raise moles or touch the score.
      for (int i = 0; i < 20; i++) begin
         hit = (i % 2 == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
         tick();
         chk("idle_mole", 32'(mole), 0);
         chk("idle_state", {score_bcd, misses, 3'(0), hit_flash, miss_flash, game_over}, 0);
      end
      hit = '0;

      // Full game table: rows are applied for one cycle and checked after the edge.
      add(1, 1, 0, 0, 8'h00, 0, 0, 0, 0);  // start
      add(1, 0, 0, 0, 8'h00, 0, 0, 0, 0);
      add(1, 1, 0, 0, 8'h00, 0, 0, 0, 0);  // start ignored in GAP
      add(1, 0, 0, 0, 8'h00, 0, 0, 0, 0);
      add(3, 0, 0, 1, 8'h00, 0, 0, 0, 0);  // mole up
      add(1, 0, 1, 0, 8'h01, 0, 1, 0, 0);  // correct hit 2 cycles after rise
      add(1, 0, 1, 0, 8'h01, 0, 0, 0, 0);  // hit in GAP ignored
      add(1, 1, 0, 0, 8'h01, 0, 0, 0, 0);  // start in GAP keeps score
      add(1, 0, 0, 0, 8'h01, 0, 0, 0, 0);
      add(1, 0, 0, 1, 8'h01, 0, 0, 0, 0);
      add(1, 0, 2, 0, 8'h01, 1, 0, 1, 0);  // wrong press -> miss
      add(1, 0, 3, 0, 8'h01, 1, 0, 0, 0);  // presses in GAP ignored
      add(2, 0, 0, 0, 8'h01, 1, 0, 0, 0);
      add(1, 0, 0, 1, 8'h01, 1, 0, 0, 0);
      add(1, 0, 3, 0, 8'h02, 1, 1, 0, 0);  // correct+wrong -> hit
      add(3, 0, 0, 0, 8'h02, 1, 0, 0, 0);
      add(3, 0, 0, 1, 8'h02, 1, 0, 0, 0);
      add(1, 1, 0, 1, 8'h02, 1, 0, 0, 0);  // start ignored in UP
      add(4, 0, 0, 1, 8'h02, 1, 0, 0, 0);  // 8 cycles up in total
      add(1, 0, 0, 0, 8'h02, 2, 0, 1, 0);  // timeout miss
      add(3, 0, 0, 0, 8'h02, 2, 0, 0, 0);
      add(8, 0, 0, 1, 8'h02, 2, 0, 0, 0);
      add(1, 0, 1, 0, 8'h03, 2, 1, 0, 0);  // hit on expiry cycle counts as hit
      add(3, 0, 0, 0, 8'h03, 2, 0, 0, 0);
      add(8, 0, 0, 1, 8'h03, 2, 0, 0, 0);
      add(1, 0, 0, 0, 8'h03, 3, 0, 1, 1);  // third miss -> OVER
      add(1, 0, 1, 0, 8'h03, 3, 0, 0, 1);
      add(1, 0, 2, 0, 8'h03, 3, 0, 0, 1);
      add(2, 0, 0, 0, 8'h03, 3, 0, 0, 1);

      prev_up = 1'b0;
      for (int r = 0; r < vecs.size(); r++) begin
         v = vecs[r];
         start = v.st;
         hit   = hitvec(v.md);
         tick();
         start = 1'b0;
         hit   = '0;
         if (v.up && !prev_up) compute_hole();
         prev_up = v.up;
         chk($sformatf("row%0d_mole", r), 32'(mole), v.up ? 32'(4'b0001 << exp_hole) : 0);
         chk($sformatf("row%0d_score", r), 32'(score_bcd), 32'(v.sc));
         chk($sformatf("row%0d_misses", r), 32'(misses), 32'(v.mi));
         chk($sformatf("row%0d_flags", r), {29'd0, hit_flash, miss_flash, game_over},
             {29'd0, v.hf, v.mf, v.go});
      end

      // Restart from OVER, then 100 quick hits: BCD carry and saturation at 99.
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("restart_score", 32'(score_bcd), 0);
      chk("restart_misses", 32'(misses), 0);
      chk("restart_go", 32'(game_over), 0);
      for (int i = 1; i <= 100; i++) begin
         wait_mole(n);
         chk("gap_len", n, 4);
         hit = 4'b0001 << exp_hole;
         tick();
         hit = '0;
         chk($sformatf("hit%0d_score", i), 32'(score_bcd), 32'(to_bcd(i < 99 ? i : 99)));
         chk($sformatf("hit%0d_flash", i), {30'd0, hit_flash, 1'b0}, {30'd0, 1'b1, 1'b0});
         chk($sformatf("hit%0d_mole", i), 32'(mole), 0);
      end

      // Asynchronous reset while the mole is up.
      wait_mole(n);
      #2 reset = 1'b1;
      m_prev_hole = 2'd0;
      #1;
      chk("async_rst_mole", 32'(mole), 0);
      chk("async_rst_score", 32'(score_bcd), 0);
      chk("async_rst_misses", 32'(misses), 0);
      chk("async_rst_flags", {29'd0, hit_flash, miss_flash, game_over}, 0);
      tick(); tick();
      reset = 1'b0;
      tick(); tick();
      chk("post_rst_idle_mole", 32'(mole), 0);
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_mole(n);
      chk("post_rst_gap_len", n, 4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
